// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive sequencer and its frame buffer.
package uart_pkg;

  localparam int          FRAME_W     = 9;
  localparam logic [15:0] DEFAULT_DIV = 16'd16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECV    = 2'd1,
    ST_CAPTURE = 2'd2
  } rx_state_t;

  // Last divider count for a given baud_div; zero is treated as a divide-by-one.
  function automatic logic [15:0] div_last16(input logic [15:0] div);
    return (div == 16'd0) ? 16'd0 : div - 16'd1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous frame FIFO, DEPTH x FRAME_W; a pop is honoured only when non-empty and a push
// into a full FIFO only when a pop frees the slot in the same cycle.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               push,
  input  logic               pop,
  input  logic [FRAME_W-1:0] wdata,
  output logic [FRAME_W-1:0] rdata,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [FRAME_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: bit-rate strobe divider, end-of-frame FSM and frame FIFO.
// Build option UART_RX_DROP_BAD_EN: discard frames flagged with a parity error.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   ST_IDLE    | waiting for the receiver to start a frame
//   ST_RECV    | frame in progress, waiting for busy to fall
//   ST_CAPTURE | one cycle: write {rx_error, rx_data} to FIFO
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             enable,
  input  logic [DIV_W-1:0] baud_div,
  output logic             rx_en,
  input  logic             rx_busy,
  input  logic [7:0]       rx_data,
  input  logic             rx_error,
  output logic [7:0]       out_data,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow,
  input  logic             clr_overflow
);

  rx_state_t          state;
  rx_state_t          state_nxt;
  logic [DIV_W-1:0]   div_cnt;
  logic [DIV_W-1:0]   div_last;
  logic               capture;
  logic               frame_ok;
  logic               push;
  logic               pop_eff;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FRAME_W-1:0] wdata;
  logic [FRAME_W-1:0] head;

  assign div_last = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);

  // >= rather than == so a shrinking baud_div wraps immediately instead of rolling over.
  always_ff @(posedge clk) begin
    if (!resetN || !enable) begin
      div_cnt <= '0;
      rx_en   <= 1'b0;
    end else if (div_cnt >= div_last) begin
      div_cnt <= '0;
      rx_en   <= 1'b1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      rx_en   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (enable && rx_busy)  state_nxt = ST_RECV;
      ST_RECV:    if (enable && !rx_busy) state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  assign capture = (state == ST_CAPTURE);

`ifdef UART_RX_DROP_BAD_EN
  assign frame_ok = ~rx_error;
  assign out_err  = 1'b0;
`else
  assign frame_ok = 1'b1;
  assign out_err  = head[FRAME_W-1];
`endif

  assign wdata    = {rx_error, rx_data};
  assign push     = capture & frame_ok;
  assign pop_eff  = out_ready & ~fifo_empty;

  always_ff @(posedge clk) begin
    if (!resetN || clr_overflow)            overflow <= 1'b0;
    else if (push && fifo_full && !pop_eff) overflow <= 1'b1;
  end

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk    (clk),
    .resetN (resetN),
    .push   (push),
    .pop    (out_ready),
    .wdata  (wdata),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign out_data  = head[7:0];
  assign out_valid = ~fifo_empty;

endmodule
